// File: rtl/bullet_engine.sv
// bullet_engine: multi-slot projectile tracker. Once per frame tick it serially erases every drawn
// bullet, advances all live bullets by STEP rows, then redraws each live bullet as a LEN-pixel
// vertical streak through a registered single-pixel write port.
module bullet_engine #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned LEN         = 4,
  parameter int unsigned STEP        = 1,
  parameter bit          DIR_UP      = 1'b1,
  parameter int unsigned Y_MAX       = 239,
  parameter logic [2:0]  COLOUR      = 3'b111
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [8:0]             fire_x,
  input  logic [7:0]             fire_y,
  output logic                   fire_ack,
  input  logic                   tick,
  input  logic [NUM_BULLETS-1:0] kill,
  output logic                   busy,
  output logic                   done,
  output logic                   plot,
  output logic [8:0]             x,
  output logic [7:0]             y,
  output logic [2:0]             colour,
  output logic [NUM_BULLETS-1:0] active
);

  localparam int unsigned SW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [SW-1:0] LastSlot = SW'(NUM_BULLETS - 1);
  localparam logic [2:0]    LastK    = 3'(LEN - 1);
  localparam logic [9:0]    YMax10   = 10'(Y_MAX);
  localparam logic [9:0]    Step10   = 10'(STEP);

  typedef enum logic [2:0] {StIdle, StErase, StMove, StDraw, StDone} state_e;

  state_e                 r_state, w_state_d;
  logic [SW-1:0]          r_slot, w_slot_d;
  logic [2:0]             r_k, w_k_d;
  logic                   r_emit, w_emit_d;  // current slot emits LEN pixels (latched at slot entry)
  logic [8:0]             r_px [NUM_BULLETS];
  logic [7:0]             r_py [NUM_BULLETS];
  logic [8:0]             w_px_d [NUM_BULLETS];
  logic [7:0]             w_py_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] r_active, w_active_d;
  logic [NUM_BULLETS-1:0] r_drawn, w_drawn_d;
  logic                   r_fire_ack;
  logic                   r_plot, w_plot_d;
  logic [8:0]             r_x, w_x_d;
  logic [7:0]             r_y, w_y_d;
  logic [2:0]             r_colour, w_col_d;

  logic                   w_scan, w_slot_end, w_last_slot;
  logic                   w_accept, w_found;
  logic [SW-1:0]          w_free_idx;
  logic [7:0]             w_ysel;
  logic [9:0]             w_y10;

  assign w_scan      = (r_state == StErase) || (r_state == StDraw);
  assign w_slot_end  = !r_emit || (r_k == LastK);
  assign w_last_slot = (r_slot == LastSlot);
  // Fire decision uses the pre-kill mask so a same-cycle kill cannot free a slot early.
  assign w_accept    = (r_state == StIdle) && fire && !(&r_active);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic: each scan phase ends when the last slot finishes.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (tick) w_state_d = StErase;
      StErase: if (w_slot_end && w_last_slot) w_state_d = StMove;
      StMove:  w_state_d = StDraw;
      StDraw:  if (w_slot_end && w_last_slot) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Lowest-index free slot for a new bullet.
  always_comb begin
    w_free_idx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (!r_active[i] && !w_found) begin
        w_free_idx = SW'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Slot state update: move, drawn bookkeeping, kill, then fire (fire wins over kill).
  always_comb begin
    w_active_d = r_active;
    w_drawn_d  = r_drawn;
    w_px_d     = r_px;
    w_py_d     = r_py;
    if (r_state == StMove) begin
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        if (r_active[i]) begin
          if (DIR_UP) begin
            if ({2'b00, r_py[i]} < Step10) w_active_d[i] = 1'b0;
            else                           w_py_d[i] = r_py[i] - 8'(STEP);
          end else begin
            if (({2'b00, r_py[i]} + Step10) > YMax10) w_active_d[i] = 1'b0;
            else                                      w_py_d[i] = r_py[i] + 8'(STEP);
          end
        end
      end
    end
    if (w_scan && r_emit && (r_k == LastK)) w_drawn_d[r_slot] = (r_state == StDraw);
    w_active_d = w_active_d & ~kill;
    if (w_accept) begin
      w_px_d[w_free_idx]     = fire_x;
      w_py_d[w_free_idx]     = fire_y;
      w_active_d[w_free_idx] = 1'b1;
    end
  end

  // Scan counters: slot index, pixel index and whether the slot emits pixels.
  always_comb begin
    w_slot_d = r_slot;
    w_k_d    = r_k;
    w_emit_d = r_emit;
    if (w_state_d != r_state) begin
      w_slot_d = '0;
      w_k_d    = '0;
      w_emit_d = (w_state_d == StErase) ? w_drawn_d[0] :
                 (w_state_d == StDraw)  ? w_active_d[0] : 1'b0;
    end else if (w_scan) begin
      if (w_slot_end) begin
        w_slot_d = r_slot + 1'b1;
        w_k_d    = '0;
        w_emit_d = (r_state == StErase) ? w_drawn_d[w_slot_d] : w_active_d[w_slot_d];
      end else begin
        w_k_d = r_k + 3'd1;
      end
    end
  end

  // Pixel output logic, evaluated on next-cycle scan state so the registered pixel lines up
  // with the scan cycle that produces it.
  always_comb begin
    w_plot_d = 1'b0;
    w_x_d    = '0;
    w_y_d    = '0;
    w_col_d  = '0;
    w_ysel   = w_py_d[w_slot_d];
    if (DIR_UP) w_y10 = {2'b00, w_ysel} - {7'd0, w_k_d};
    else        w_y10 = {2'b00, w_ysel} + {7'd0, w_k_d};
    // Off-screen pixels still consume their cycle, just without a write strobe.
    if (((w_state_d == StErase) || (w_state_d == StDraw)) && w_emit_d &&
        !w_y10[9] && (w_y10 <= YMax10)) begin
      w_plot_d = 1'b1;
      w_x_d    = w_px_d[w_slot_d];
      w_y_d    = w_y10[7:0];
      w_col_d  = (w_state_d == StDraw) ? COLOUR : 3'b000;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot     <= '0;
      r_k        <= '0;
      r_emit     <= 1'b0;
      r_active   <= '0;
      r_drawn    <= '0;
      r_fire_ack <= 1'b0;
      r_plot     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        r_px[i] <= '0;
        r_py[i] <= '0;
      end
    end else begin
      r_slot     <= w_slot_d;
      r_k        <= w_k_d;
      r_emit     <= w_emit_d;
      r_active   <= w_active_d;
      r_drawn    <= w_drawn_d;
      r_fire_ack <= w_accept;
      r_plot     <= w_plot_d;
      r_x        <= w_x_d;
      r_y        <= w_y_d;
      r_colour   <= w_col_d;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        r_px[i] <= w_px_d[i];
        r_py[i] <= w_py_d[i];
      end
    end
  end

  assign fire_ack = r_fire_ack;
  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StDone);
  assign plot     = r_plot;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_colour;
  assign active   = r_active;

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: directed plus randomized checks of bullet_engine against a frame-level model
// that lists the expected pixel stream for each frame.
module tb_bullet_engine;

  localparam int          N      = 4;
  localparam int          LEN    = 4;
  localparam int          STEP   = 1;
  localparam bit          DIR_UP = 1'b1;
  localparam int          Y_MAX  = 239;
  localparam logic [2:0]  COL    = 3'b111;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fire = 1'b0;
  logic [8:0]   fire_x = '0;
  logic [7:0]   fire_y = '0;
  logic         fire_ack;
  logic         tick = 1'b0;
  logic [N-1:0] kill = '0;
  logic         busy, done, plot;
  logic [8:0]   x;
  logic [7:0]   y;
  logic [2:0]   colour;
  logic [N-1:0] active;

  bullet_engine #(
    .NUM_BULLETS(N),
    .LEN        (LEN),
    .STEP       (STEP),
    .DIR_UP     (DIR_UP),
    .Y_MAX      (Y_MAX),
    .COLOUR     (COL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fire    (fire),
    .fire_x  (fire_x),
    .fire_y  (fire_y),
    .fire_ack(fire_ack),
    .tick    (tick),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .plot    (plot),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .active  (active)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level model of the bullet slots.
  int m_px[N];
  int m_py[N];
  bit m_act[N];
  bit m_drawn[N];
  int m_elen;

  typedef struct {
    bit plot;
    int x;
    int y;
    int col;
    bit done;
  } pix_t;

  pix_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = m_act[i];
    return m;
  endfunction

  function automatic pix_t mk(bit p, int px, int py, int c, bit d);
    pix_t e;
    e.plot = p; e.x = px; e.y = py; e.col = c; e.done = d;
    return e;
  endfunction

  function automatic pix_t pixel(int i, int k, int c);
    int yk;
    yk = DIR_UP ? (m_py[i] - k) : (m_py[i] + k);
    if (yk >= 0 && yk <= Y_MAX) return mk(1'b1, m_px[i], yk, c, 1'b0);
    return mk(1'b0, 0, 0, 0, 1'b0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_act[i] = 1'b0; m_drawn[i] = 1'b0;
    end
  endtask

  task automatic model_fire(input int fx, input int fy, output bit acc);
    acc = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!m_act[i] && !acc) begin
        m_px[i] = fx; m_py[i] = fy; m_act[i] = 1'b1; acc = 1'b1;
      end
    end
  endtask

  // Expected per-cycle output list for one frame; also advances the model.
  task automatic build_frame();
    exp_q.delete();
    m_elen = 0;
    for (int i = 0; i < N; i++) begin
      if (m_drawn[i]) begin
        for (int k = 0; k < LEN; k++) exp_q.push_back(pixel(i, k, 0));
        m_drawn[i] = 1'b0;
        m_elen += LEN;
      end else begin
        exp_q.push_back(mk(1'b0, 0, 0, 0, 1'b0));
        m_elen += 1;
      end
    end
    exp_q.push_back(mk(1'b0, 0, 0, 0, 1'b0));
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (DIR_UP) begin
          if (m_py[i] < STEP) m_act[i] = 1'b0;
          else m_py[i] -= STEP;
        end else begin
          if (m_py[i] + STEP > Y_MAX) m_act[i] = 1'b0;
          else m_py[i] += STEP;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        for (int k = 0; k < LEN; k++) exp_q.push_back(pixel(i, k, int'(COL)));
        m_drawn[i] = 1'b1;
      end else begin
        exp_q.push_back(mk(1'b0, 0, 0, 0, 1'b0));
      end
    end
    exp_q.push_back(mk(1'b0, 0, 0, 0, 1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_fire_ack"}, fire_ack, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_active"}, active, 0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic fire_once(input int fx, input int fy);
    bit acc;
    fire = 1'b1; fire_x = 9'(fx); fire_y = 8'(fy);
    step();
    model_fire(fx, fy, acc);
    check("fire_ack", fire_ack, acc);
    fire = 1'b0;
    check("fire_active", active, model_mask());
    step();
    check("fire_ack_pulse", fire_ack, 0);
    check("idle_busy", busy, 0);
  endtask

  // Runs one frame; optionally fires in the tick cycle and/or resets in the second DRAW cycle.
  task automatic run_frame(input bit with_fire, input int fx, input int fy, input bit abort);
    bit acc;
    int abort_at;
    acc = 1'b0;
    tick = 1'b1;
    if (with_fire) begin
      fire = 1'b1; fire_x = 9'(fx); fire_y = 8'(fy);
    end
    step();
    tick = 1'b0;
    fire = 1'b0;
    if (with_fire) model_fire(fx, fy, acc);
    build_frame();
    abort_at = abort ? (m_elen + 2) : -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        do_reset("abort");
        return;
      end
      check("frame_plot", plot, exp_q[i].plot);
      if (exp_q[i].plot) begin
        check("frame_x", x, exp_q[i].x);
        check("frame_y", y, exp_q[i].y);
        check("frame_colour", colour, exp_q[i].col);
      end
      check("frame_done", done, exp_q[i].done);
      check("frame_busy", busy, 1);
      check("frame_fire_ack", fire_ack, (i == 0) ? 32'(acc) : 32'd0);
      step();
    end
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_plot", plot, 0);
    check("post_active", active, model_mask());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    do_reset("reset");

    // First shot and two frames of flight.
    fire_once(100, 50);
    check("single_active", active, 4'b0001);
    run_frame(1'b0, 0, 0, 1'b0);
    run_frame(1'b0, 0, 0, 1'b0);

    // Saturate all slots; a held fifth fire waits for a kill.
    do_reset("reset2");
    for (int i = 0; i < N; i++) fire_once(40 + 10 * i, 100 + i);
    fire = 1'b1; fire_x = 9'd77; fire_y = 8'd88;
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_no_ack", fire_ack, 0);
    end
    kill = 4'b0100;
    step();
    m_act[2] = 1'b0;
    check("kill_no_ack", fire_ack, 0);
    check("kill_active", active, model_mask());
    kill = '0;
    step();
    begin
      bit acc;
      model_fire(77, 88, acc);
      check("refire_ack", fire_ack, acc);
    end
    fire = 1'b0;
    check("refire_active", active, 4'b1111);
    step();
    run_frame(1'b0, 0, 0, 1'b0);

    // Bullet at the top edge leaves the screen.
    do_reset("reset3");
    fire_once(20, 0);
    run_frame(1'b0, 0, 0, 1'b0);
    check("edge_gone", active, 0);
    run_frame(1'b0, 0, 0, 1'b0);

    // Partially visible streak, then tick and fire together.
    do_reset("reset4");
    fire_once(10, 2);
    run_frame(1'b0, 0, 0, 1'b0);
    run_frame(1'b1, 30, 100, 1'b0);

    // Reset during DRAW, then normal operation resumes.
    fire_once(50, 60);
    run_frame(1'b0, 0, 0, 1'b1);
    fire_once(200, 120);
    run_frame(1'b0, 0, 0, 1'b0);

    // Randomized mix of fires, kills and ticks.
    for (int it = 0; it < 40; it++) begin
      int sel;
      int rx;
      int ry;
      sel = $urandom_range(0, 3);
      rx  = $urandom_range(0, 319);
      ry  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 239);
      case (sel)
        0: fire_once(rx, ry);
        1: run_frame(1'b0, 0, 0, 1'b0);
        2: begin
          logic [N-1:0] km;
          km = N'($urandom_range(0, (1 << N) - 1));
          kill = km;
          step();
          kill = '0;
          for (int i = 0; i < N; i++) if (km[i]) m_act[i] = 1'b0;
          check("rand_kill_active", active, model_mask());
        end
        default: run_frame(1'b1, rx, ry, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
